// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral: FSM state encoding and default sizing.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } spi_state_e;

   localparam int SPI_WIDTH_DEFAULT = 8;
   localparam int SPI_SYNC_MIN      = 2;

endpackage

// File: rtl/spi_sync.sv
// N-stage flop synchronizer for one asynchronous input; reset level is a parameter.
module spi_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// Oversampling SPI responder (mode 0) with valid/ready TX/RX byte interfaces.
// Optional sticky overrun flag: define SPI_PERIPHERAL_OVERRUN_EN.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | CS high, MISO low, counter and shifters cleared
//  ST_LOAD  | one cycle: take holding word (or zeros) and drive first bit
//  ST_SHIFT | sample MOSI on SCK rise, advance MISO on SCK fall
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int WIDTH       = SPI_WIDTH_DEFAULT,
   parameter bit LSB_FIRST   = 1'b1,
   parameter int SYNC_STAGES = SPI_SYNC_MIN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             spiCsN,
   input  logic             spiClk,
   input  logic             spiIn,
   output logic             spiOut,
   input  logic [WIDTH-1:0] dataTx,
   input  logic             txValid,
   output logic             txReady,
   output logic [WIDTH-1:0] dataRx,
   output logic             rxValid,
   input  logic             rxReady,
   output logic             rxOverrun,
   input  logic             overrunClear
);

   localparam int SYNC_N    = (SYNC_STAGES < SPI_SYNC_MIN) ? SPI_SYNC_MIN : SYNC_STAGES;
   localparam int CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int FIRST_BIT = LSB_FIRST ? 0 : WIDTH - 1;

   logic cs_s, sck_s, mosi_s;

   // CS synchronizer resets high so a reset release never looks like a frame start.
   spi_sync #(.STAGES(SYNC_N), .RESET_VAL(1'b1)) u_sync_cs (
      .clk(clk), .reset(reset), .d(spiCsN), .q(cs_s));
   spi_sync #(.STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_sck (
      .clk(clk), .reset(reset), .d(spiClk), .q(sck_s));
   spi_sync #(.STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset(reset), .d(spiIn), .q(mosi_s));

   spi_state_e       state_q, state_d;
   logic             sck_hist_q, sck_hist_d;
   logic             sck_rise_q, sck_rise_d;
   logic             sck_fall_q, sck_fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
   logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             tx_ready_q, tx_ready_d;
   logic             spi_out_q, spi_out_d;
   logic [WIDTH-1:0] data_rx_q, data_rx_d;
   logic             rx_valid_q, rx_valid_d;
   logic             rx_done;
   logic [WIDTH-1:0] tx_word, tx_next, rx_next;

   always_comb begin
      sck_hist_d = sck_s;
      sck_rise_d = sck_s & ~sck_hist_q;
      sck_fall_d = ~sck_s & sck_hist_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      hold_d     = hold_q;
      tx_ready_d = tx_ready_q;
      spi_out_d  = spi_out_q;
      data_rx_d  = data_rx_q;
      rx_valid_d = rx_valid_q;
      rx_done    = 1'b0;
      tx_word    = hold_q;
      tx_next    = LSB_FIRST ? (tx_sh_q >> 1) : (tx_sh_q << 1);
      rx_next    = LSB_FIRST ? {mosi_s, rx_sh_q[WIDTH-1:1]} : {rx_sh_q[WIDTH-2:0], mosi_s};

      if ((state_q != ST_IDLE) && cs_s) begin
         state_d   = ST_IDLE;
         spi_out_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               spi_out_d = 1'b0;
               cnt_d     = '0;
               last_d    = 1'b0;
               tx_sh_d   = '0;
               rx_sh_d   = '0;
               if (!cs_s) state_d = ST_LOAD;
            end
            ST_LOAD: begin
               // An empty holding register sends zeros without flagging anything.
               if (tx_ready_q) tx_word = '0;
               tx_sh_d    = tx_word;
               spi_out_d  = tx_word[FIRST_BIT];
               tx_ready_d = 1'b1;
               cnt_d      = '0;
               last_d     = 1'b0;
               state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
               if (sck_rise_q) begin
                  rx_sh_d = rx_next;
                  if (cnt_q == CNT_W'(WIDTH - 1)) begin
                     rx_done   = 1'b1;
                     data_rx_d = rx_next;
                     cnt_d     = '0;
                     last_d    = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               if (sck_fall_q) begin
                  if (last_q) begin
                     state_d = ST_LOAD;
                  end else begin
                     tx_sh_d   = tx_next;
                     spi_out_d = tx_next[FIRST_BIT];
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (txValid && tx_ready_q) begin
         hold_d     = dataTx;
         tx_ready_d = 1'b0;
      end

      if (rx_done) begin
         rx_valid_d = 1'b1;
      end else if (rx_valid_q && rxReady) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         sck_hist_q <= 1'b0;
         sck_rise_q <= 1'b0;
         sck_fall_q <= 1'b0;
         cnt_q      <= '0;
         last_q     <= 1'b0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         hold_q     <= '0;
         tx_ready_q <= 1'b1;
         spi_out_q  <= 1'b0;
         data_rx_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sck_hist_q <= sck_hist_d;
         sck_rise_q <= sck_rise_d;
         sck_fall_q <= sck_fall_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         hold_q     <= hold_d;
         tx_ready_q <= tx_ready_d;
         spi_out_q  <= spi_out_d;
         data_rx_q  <= data_rx_d;
         rx_valid_q <= rx_valid_d;
      end
   end

`ifdef SPI_PERIPHERAL_OVERRUN_EN
   logic overrun_q, overrun_d;

   // Overwrite of an unconsumed word; a same-cycle rxReady counts as consumed.
   always_comb begin
      overrun_d = overrun_q;
      if (overrunClear) overrun_d = 1'b0;
      if (rx_done && rx_valid_q && !rxReady) overrun_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
      end
   end

   assign rxOverrun = overrun_q;
`else
   logic unused_overrun_clear;
   assign unused_overrun_clear = overrunClear;
   assign rxOverrun            = 1'b0;
`endif

   assign spiOut  = spi_out_q;
   assign txReady = tx_ready_q;
   assign dataRx  = data_rx_q;
   assign rxValid = rx_valid_q;

endmodule
